updown_pulse_driver: RTL

Synchronous command-driven controller that drives the clock, load and reset pins of a 74LS192-style up/down decade counter. It sits on the driving side of the `CPu`/`CPd`/`PL_n`/`MR`/`P3..P0` interface and reads back `Q3..Q0`, `TCu_n` and `TCd_n`. A host issues load, clear, count-up or count-down bursts through a valid/ready handshake. The block keeps a BCD shadow of the expected count and flags any mismatch with the counter's outputs.

---
 rtl/updown_pulse_driver_if.sv | 18 +
 rtl/updown_pulse_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_pulse_driver_if.sv
// rtl/updown_pulse_driver_if.sv - command handshake bundle for updown_pulse_driver
//
// Signals:
//   cmd_valid  host -> driver  command present
//   cmd_ready  driver -> host  driver idle and able to take a command
//   cmd_op     host -> driver  00 load, 01 count up, 10 count down, 11 clear
//   cmd_cnt    host -> driver  pulses per up/down burst, 0 means 16
//   cmd_data   host -> driver  load value
interface updown_pulse_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_cnt;
    logic [3:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_cnt, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_cnt, input cmd_data, output cmd_ready);
endinterface

// File: rtl/updown_pulse_driver.sv
// rtl/updown_pulse_driver.sv - pulse driver and BCD shadow checker for a 74LS192-style counter
//
// Ports:
//   CP, MR_n                 clock (rising edge) and asynchronous active-low reset
//   cmd                      command handshake (updown_pulse_driver_if.slave)
//   CPu, CPd                 count pulses, idle high, counter steps on the rising edge
//   PL_n, MR                 parallel load (active low), counter master reset (active high)
//   P3..P0                   load data
//   Q3..Q0, TCu_n, TCd_n     counter state and terminal counts read back
//   exp_q                    shadow of the expected count
//   busy, done, err          not idle, one-clock completion pulse, sticky mismatch flag
//
// Optional feature: define UPDOWN_TC_STOP_EN to end an up/down burst after the
// pulse during which the relevant terminal count was seen low.
module updown_pulse_driver #(
    parameter int LOW_CYCLES  = 2,
    parameter int HIGH_CYCLES = 2
) (
    input  logic                        CP,
    input  logic                        MR_n,
    updown_pulse_driver_if.slave        cmd,
    output logic                        CPu,
    output logic                        CPd,
    output logic                        PL_n,
    output logic                        MR,
    output logic                        P3,
    output logic                        P2,
    output logic                        P1,
    output logic                        P0,
    input  logic                        Q3,
    input  logic                        Q2,
    input  logic                        Q1,
    input  logic                        Q0,
    input  logic                        TCu_n,
    input  logic                        TCd_n,
    output logic [3:0]                  exp_q,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    typedef enum logic [1:0] {IDLE, ACTIVE, INACTIVE, DONE} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // {CPu, CPd, PL_n, MR} with every control at its idle level
    localparam logic [3:0] CTL_IDLE = 4'b1110;

    state_t      state;
    logic [1:0]  op;
    logic [3:0]  data;
    logic [4:0]  remaining;
    logic [15:0] timer;
    logic        launch;
    logic        ready_q;
    logic [3:0]  p;
    logic [3:0]  q;
    logic        tc_low;
    logic        tc_want;
    logic        stop_burst;

    assign q              = {Q3, Q2, Q1, Q0};
    assign {P3, P2, P1, P0} = p;
    assign cmd.cmd_ready  = ready_q;

    function automatic logic [3:0] active_ctl(input logic [1:0] o);
        case (o)
            OP_LOAD: return 4'b1100;
            OP_UP:   return 4'b0110;
            OP_DOWN: return 4'b1010;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] next_exp(input logic [1:0] o, input logic [3:0] cur, input logic [3:0] d);
        case (o)
            OP_LOAD: return d;
            OP_UP:   return (cur == 4'd9) ? 4'd0 : cur + 4'd1;
            OP_DOWN: return (cur == 4'd0) ? 4'd9 : cur - 4'd1;
            default: return 4'd0;
        endcase
    endfunction

    // Terminal count seen on the pin versus what the shadow count says it should be.
    // Load and clear never look at TC.
    always_comb begin
        tc_low  = 1'b0;
        tc_want = 1'b0;
        case (op)
            OP_UP: begin
                tc_low  = ~TCu_n;
                tc_want = (exp_q == 4'd9);
            end
            OP_DOWN: begin
                tc_low  = ~TCd_n;
                tc_want = (exp_q == 4'd0);
            end
            default: ;
        endcase
    end

`ifdef UPDOWN_TC_STOP_EN
    logic tc_seen;

    always_ff @(posedge CP or negedge MR_n) begin
        if (!MR_n) begin
            tc_seen <= 1'b0;
        end else if (state == IDLE) begin
            tc_seen <= 1'b0;
        end else if (state == ACTIVE && !launch && tc_low) begin
            tc_seen <= 1'b1;
        end
    end

    assign stop_burst = tc_seen;
`else
    assign stop_burst = 1'b0;
`endif

    // launch marks the first ACTIVE clock after acceptance: controls are driven
    // one edge after the handshake, which accounts for the extra clock of latency.
    always_ff @(posedge CP or negedge MR_n) begin
        if (!MR_n) begin
            state                  <= IDLE;
            {CPu, CPd, PL_n, MR}   <= 4'b1111;
            p                      <= 4'd0;
            exp_q                  <= 4'd0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            err                    <= 1'b0;
            ready_q                <= 1'b0;
            op                     <= OP_LOAD;
            data                   <= 4'd0;
            remaining              <= 5'd0;
            timer                  <= 16'd0;
            launch                 <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    MR      <= 1'b0;
                    ready_q <= 1'b1;
                    if (cmd.cmd_valid && ready_q) begin
                        ready_q <= 1'b0;
                        busy    <= 1'b1;
                        op      <= cmd.cmd_op;
                        data    <= cmd.cmd_data;
                        if (cmd.cmd_op == OP_UP || cmd.cmd_op == OP_DOWN) begin
                            remaining <= (cmd.cmd_cnt == 4'd0) ? 5'd16 : {1'b0, cmd.cmd_cnt};
                        end else begin
                            remaining <= 5'd1;
                        end
                        if (cmd.cmd_op == OP_LOAD && cmd.cmd_data > 4'd9) begin
                            err <= 1'b1;
                        end
                        launch <= 1'b1;
                        timer  <= 16'd0;
                        state  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (launch) begin
                        launch               <= 1'b0;
                        timer                <= 16'd0;
                        {CPu, CPd, PL_n, MR} <= active_ctl(op);
                        if (op == OP_LOAD) begin
                            p <= data;
                        end
                    end else begin
                        if (tc_low != tc_want) begin
                            err <= 1'b1;
                        end
                        if (timer == 16'(LOW_CYCLES - 1)) begin
                            {CPu, CPd, PL_n, MR} <= CTL_IDLE;
                            exp_q                <= next_exp(op, exp_q, data);
                            remaining            <= remaining - 5'd1;
                            timer                <= 16'd0;
                            state                <= INACTIVE;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                INACTIVE: begin
                    if (timer == 16'(HIGH_CYCLES - 1)) begin
                        if (q != exp_q) begin
                            err <= 1'b1;
                        end
                        timer <= 16'd0;
                        if (remaining != 5'd0 && !stop_burst) begin
                            {CPu, CPd, PL_n, MR} <= active_ctl(op);
                            state                <= ACTIVE;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
